adc_decimator: RTL

//  Post-processing stage directly downstream of the thermometer-to-binary encoder (therm).

---
 rtl/adc_decimator.sv | 115 +++++++++++
 1 files changed

// File: rtl/adc_decimator.sv
// Boxcar decimator for flash-ADC codes: averages 2**LOG2_AVG samples and
// queues each average in a show-ahead FIFO drained by a valid/ready consumer.
module adc_decimator #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned LOG2_AVG   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 clr,
  input  logic [DATA_W-1:0]                    b,
  output logic [DATA_W-1:0]                    dout,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic                                 ovf
);

  localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LOG2_AVG-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_AVG-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic [ACC_W-1:0]    sum_c;
  logic                push_c, pop_c, wr_en_c;
  logic [DATA_W-1:0]   wr_data_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Accumulate, decide push/pop and FIFO bookkeeping; clr overrides all.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    wr_en_c   = 1'b0;
    sum_c     = acc_q + ACC_W'(b);
    wr_data_c = DATA_W'(sum_c >> LOG2_AVG);
    push_c    = en && (cnt_q == CNT_MAX);
    pop_c     = (level_q != '0) && out_ready;

    if (clr) begin
      acc_d    = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (en) begin
        if (cnt_q == CNT_MAX) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum_c;
          cnt_d = cnt_q + LOG2_AVG'(1);
        end
      end
      if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (push_c && ((level_q != LVL_FULL) || pop_c)) begin
        wr_en_c  = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else if (push_c) begin
        ovf_d = 1'b1;
      end
      if (wr_en_c && !pop_c)      level_d = level_q + LVL_W'(1);
      else if (!wr_en_c && pop_c) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are qualified by level, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wr_data_c;
  end

  assign out_valid = (level_q != '0);
  assign dout      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;

endmodule
